// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: checks a 4-bit down-count stream for legal steps, counts wraps,
// and queues each wrap's epoch number in a fall-through FIFO drained by valid/ready.
module ripple_count_monitor #(
  parameter int CNT_W      = 4,
  parameter int EPOCH_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [CNT_W-1:0]   q_in,
  input  logic               err_clr,
  input  logic               wrap_ready,
  output logic               wrap_valid,
  output logic [EPOCH_W-1:0] wrap_epoch,
  output logic [CNT_W-1:0]   cur_count,
  output logic               seq_err,
  output logic               overflow,
  output logic               fifo_full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ERROR} state_t;

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cur;
  logic [EPOCH_W-1:0] r_epoch;
  logic [EPOCH_W-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_cnt;
  logic               r_seq_err, r_ovf;

  logic [CNT_W-1:0]   w_dec;
  logic [EPOCH_W-1:0] w_epoch_inc;
  logic               w_check, w_legal, w_bad, w_wrap, w_pop, w_full, w_push;

  assign w_dec       = r_cur - 1'b1;
  assign w_epoch_inc = r_epoch + 1'b1;
  assign w_check     = sample_en && r_state == S_TRACK;
  assign w_legal     = q_in == r_cur || q_in == w_dec || q_in == '0;
  assign w_bad       = w_check && !w_legal;
  // err_clr suppresses the check on its edge, wrap detection included
  assign w_wrap      = w_check && !err_clr && r_cur == '0 && q_in == '1;
  assign w_full      = r_cnt == FULL;
  assign w_pop       = wrap_valid && wrap_ready;
  assign w_push      = w_wrap && (!w_full || w_pop);

  always_comb begin
    w_nxt = r_state;
    if (err_clr) w_nxt = S_IDLE;
    else if (sample_en) w_nxt = r_state == S_IDLE ? S_TRACK : w_bad ? S_ERROR : r_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_epoch   <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_seq_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      if (sample_en) r_cur <= q_in;
      if (w_wrap) r_epoch <= w_epoch_inc;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt     <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_seq_err <= !err_clr && (r_seq_err || w_bad);
      r_ovf     <= !err_clr && (r_ovf || (w_wrap && w_full && !w_pop));
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= w_epoch_inc;

  assign wrap_valid = r_cnt != '0;
  assign wrap_epoch = wrap_valid ? r_fifo[r_rp] : '0;
  assign cur_count  = r_cur;
  assign seq_err    = r_seq_err;
  assign overflow   = r_ovf;
  assign fifo_full  = w_full;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: directed plus randomized stimulus against a queue-based reference model.
module tb_ripple_count_monitor;
  logic       clk = 0, reset = 0, sample_en = 0, err_clr = 0, wrap_ready = 0;
  logic [3:0] q_in = 0;
  logic       wrap_valid, seq_err, overflow, fifo_full;
  logic [7:0] wrap_epoch;
  logic [3:0] cur_count;

  ripple_count_monitor dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in), .err_clr(err_clr),
    .wrap_ready(wrap_ready), .wrap_valid(wrap_valid), .wrap_epoch(wrap_epoch),
    .cur_count(cur_count), .seq_err(seq_err), .overflow(overflow), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int m_mode = 0;
  int m_cur = 0, m_epoch = 0, m_err = 0, m_ovf = 0;
  int mq[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 tracking, 2 error
  task automatic model();
    bit pop, wrap, bad;
    int qv;
    qv = int'(q_in);
    if (!reset) begin
      m_mode = 0; m_cur = 0; m_epoch = 0; m_err = 0; m_ovf = 0; mq.delete();
      return;
    end
    pop = mq.size() > 0 && wrap_ready;
    wrap = 0; bad = 0;
    if (!err_clr && sample_en && m_mode == 1) begin
      if (m_cur == 0 && qv == 15) wrap = 1;
      else if (!(qv == m_cur || qv == (m_cur + 15) % 16 || qv == 0)) bad = 1;
    end
    if (err_clr) begin
      m_mode = 0; m_err = 0; m_ovf = 0;
    end else if (sample_en) begin
      if (m_mode == 0) m_mode = 1;
      else if (bad) begin m_mode = 2; m_err = 1; end
    end
    if (sample_en) m_cur = qv;
    if (pop) void'(mq.pop_front());
    if (wrap) begin
      m_epoch = (m_epoch + 1) % 256;
      if (mq.size() < 4) mq.push_back(m_epoch);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("wrap_valid", wrap_valid, mq.size() > 0);
    chk("wrap_epoch", wrap_epoch, mq.size() > 0 ? mq[0] : 0);
    chk("cur_count", cur_count, m_cur);
    chk("seq_err", seq_err, m_err);
    chk("overflow", overflow, m_ovf);
    chk("fifo_full", fifo_full, mq.size() == 4);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  task automatic feed(input int v);
    sample_en = 1; q_in = 4'(v);
    step();
  endtask

  task automatic full_cycle();
    for (int v = 15; v >= 0; v--) feed(v);
  endtask

  initial begin
    reset = 0; sample_en = 1; q_in = 4'b1010;
    step(); step();
    reset = 1;
    feed(10);
    chk("first_load", cur_count, 10);
    wrap_ready = 1;
    feed(0);
    full_cycle();
    full_cycle();
    feed(15);
    wrap_ready = 0;
    feed(14);
    for (int w = 0; w < 5; w++) begin
      for (int v = 13 - ((w == 0) ? 0 : 0); v >= 0; v--) feed(v);
      feed(15); feed(14);
    end
    chk("ovf_set", overflow, 1);
    sample_en = 0; wrap_ready = 1;
    for (int i = 0; i < 5; i++) step();
    wrap_ready = 0;
    for (int w = 0; w < 4; w++) begin
      for (int v = 13; v >= 0; v--) feed(v);
      feed(15); feed(14);
    end
    for (int v = 13; v >= 0; v--) feed(v);
    wrap_ready = 1;
    feed(15);
    chk("full_push_pop", fifo_full, 1);
    feed(12); feed(9);
    chk("seq_err_set", seq_err, 1);
    feed(0); feed(15);
    err_clr = 1; feed(14); err_clr = 0;
    feed(5); feed(4);
    wrap_ready = 0;
    feed(0); feed(15); feed(14); feed(0); feed(15);
    reset = 0; step(); reset = 1;
    feed(0); feed(15);
    chk("epoch_restart", wrap_epoch, 1);
    wrap_ready = 1;
    for (int w = 0; w < 260; w++) full_cycle();
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      sample_en  = $urandom_range(0, 9) < 8;
      wrap_ready = $urandom_range(0, 1) == 1;
      err_clr    = $urandom_range(0, 49) == 0;
      reset      = $urandom_range(0, 299) != 0;
      q_in = r < 4 ? 4'(m_cur) : r < 8 ? 4'((m_cur + 15) % 16) : r == 8 ? 4'd0 : 4'($urandom_range(0, 15));
      step();
    end
    reset = 1; err_clr = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
